// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t     : SRAM access FSM encoding (IDLE, LO, HI, DONE)
//   MEM_BASE    : default data-address offset removed before SRAM mapping
//   SRAM_DW/AW  : off-chip SRAM data and halfword-address widths
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] MEM_BASE = 32'd1024;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;
  // One address bit selects the half, the rest index the 32-bit word.
  localparam int WORD_IDX_W = SRAM_AW - 1;

endpackage

// File: rtl/mem_stage_sram_controller.sv
// sram_controller: moves one 32-bit word to/from a 16-bit SRAM as two
// halfword phases, each held for PHASE_CYCLES cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_r_en, mem_w_en  : load / store request (mutually exclusive)
//   word_idx            : mapped word index (SRAM address without half bit)
//   st_val              : store word
//   ready               : 1 when the stage may advance
//   mem_res             : last completed load word
//   sram_addr/dq/we_n   : SRAM pins
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [WORD_IDX_W-1:0] word_idx,
  input  logic [31:0]           st_val,
  output logic                  ready,
  output logic [31:0]           mem_res,
  output logic [SRAM_AW-1:0]    sram_addr,
  inout  wire  [SRAM_DW-1:0]    sram_dq,
  output logic                  sram_we_n
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hi_sel;  // 1 only while the high half is on the bus
  logic             req;
  logic             last;

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == CNT_LAST);

  // A request seen in IDLE stalls at once; DONE releases the pipeline even
  // though the completing instruction still holds its request.
  assign ready = (state == DONE) || ((state == IDLE) && !req);

  assign sram_addr = {word_idx, hi_sel};

  // Drive the bus only while a write phase is active; sram_we_n is reset
  // asynchronously, so a reset mid-write releases the bus immediately.
  assign sram_dq = sram_we_n ? {SRAM_DW{1'bz}}
                             : (hi_sel ? st_val[31:16] : st_val[15:0]);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including mem_res) has an async reset value so a partially
  // read word is discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_sel    <= 1'b0;
      sram_we_n <= 1'b1;
      mem_res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= LO;
            cnt       <= '0;
            hi_sel    <= 1'b0;
            sram_we_n <= ~mem_w_en;
          end
        end
        LO: begin
          if (last) begin
            state  <= HI;
            cnt    <= '0;
            hi_sel <= 1'b1;
            if (mem_r_en) mem_res[15:0] <= sram_dq;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            hi_sel    <= 1'b0;
            sram_we_n <= 1'b1;
            if (mem_r_en) mem_res[31:16] <= sram_dq;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The request still present here belongs to the finishing
        // instruction; never restart from DONE.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Maps the ALU result onto the
// 16-bit SRAM and stalls the pipeline (ready=0) until the word transfer ends.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_r_en, mem_w_en  : load / store request
//   alu_res             : byte address from execute
//   st_val              : store data
//   ready               : 0 freezes pipeline registers and PC
//   mem_res             : last completed load word
//   SRAM_ADDR/DQ/WE_N   : off-chip SRAM pins
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] MEM_BASE     = mem_stage_pkg::MEM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        st_val,
  output logic               ready,
  output logic [31:0]        mem_res,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N
);

  // Offset wraps modulo 2^32; only bits [18:2] reach the SRAM, with no
  // range check. Byte offset bits within the word are ignored.
  logic [31:0] mapped;
  logic        unused_mapped_bits;

  assign mapped             = alu_res - MEM_BASE;
  assign unused_mapped_bits = ^{mapped[31:19], mapped[1:0]};

  sram_controller #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_sram_controller (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .word_idx (mapped[18:2]),
    .st_val   (st_val),
    .ready    (ready),
    .mem_res  (mem_res),
    .sram_addr(SRAM_ADDR),
    .sram_dq  (SRAM_DQ),
    .sram_we_n(SRAM_WE_N)
  );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic        ready;
  logic [31:0] mem_res;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  mem_stage dut (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .alu_res  (alu_res),
    .st_val   (st_val),
    .ready    (ready),
    .mem_res  (mem_res),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_WE_N(SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus during loads, captures writes on the edge.
  logic [15:0] sram_mem [0:262143];
  logic        preload;

  assign SRAM_DQ = (mem_r_en && !rst) ? sram_mem[SRAM_ADDR] : 16'hzzzz;

  always @(posedge clk) begin
    if (preload) begin
      sram_mem[18'h3FE00] <= 16'hCAFE;
      sram_mem[18'h3FE01] <= 16'hF00D;
    end else if (!SRAM_WE_N) begin
      sram_mem[SRAM_ADDR] <= SRAM_DQ;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard entries: one per stalled cycle, one per completion.
  typedef struct {
    logic [17:0] addr;
    logic        we_n;
    logic [15:0] dq;
    int          dq_mode;  // 0 unchecked, 1 must float, 2 must equal dq
  } bus_exp_t;

  typedef struct {
    int          stalls;
    logic [31:0] res;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int        stall_cnt;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else if (!(mem_r_en || mem_w_en)) begin
      check("idle_ready", {31'b0, ready}, 32'd1);
      check("idle_we_n", {31'b0, SRAM_WE_N}, 32'd1);
      check("idle_dq_z", {31'b0, SRAM_DQ === 16'hzzzz}, 32'd1);
    end else if (!ready) begin
      stall_cnt++;
      if (bus_q.size() == 0) begin
        check("bus_q_underflow", 32'd1, 32'd0);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_addr", {14'b0, SRAM_ADDR}, {14'b0, e.addr});
        check("bus_we_n", {31'b0, SRAM_WE_N}, {31'b0, e.we_n});
        if (e.dq_mode == 1)
          check("bus_dq_z", {31'b0, SRAM_DQ === 16'hzzzz}, 32'd1);
        else if (e.dq_mode == 2)
          check("bus_dq", {16'b0, SRAM_DQ}, {16'b0, e.dq});
      end
    end else begin
      if (done_q.size() == 0) begin
        check("done_q_underflow", 32'd1, 32'd0);
      end else begin
        done_exp_t d;
        d = done_q.pop_front();
        check("stall_cycles", stall_cnt, d.stalls);
        check("mem_res", mem_res, d.res);
      end
      stall_cnt = 0;
    end
  end

  task automatic push_bus(input logic [17:0] addr, input logic we_n,
                          input logic [15:0] dq, input int dq_mode);
    bus_exp_t e;
    e.addr = addr; e.we_n = we_n; e.dq = dq; e.dq_mode = dq_mode;
    bus_q.push_back(e);
  endtask

  // Issue one memory op at posedge+1 and return at posedge+1 after DONE.
  // lo_addr and exp_res are hand-computed by the caller.
  task automatic do_op(input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] st, input logic [17:0] lo_addr,
                       input logic [31:0] exp_res);
    done_exp_t d;
    bit        got_ready;
    push_bus(lo_addr, 1'b1, 16'h0, w ? 1 : 0);
    for (int i = 0; i < 2; i++) push_bus(lo_addr, ~w, st[15:0], w ? 2 : 0);
    for (int i = 0; i < 2; i++) push_bus(lo_addr | 18'd1, ~w, st[31:16], w ? 2 : 0);
    d.stalls = 5; d.res = exp_res;
    done_q.push_back(d);
    mem_r_en = r; mem_w_en = w; alu_res = alu; st_val = st;
    got_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    if (!got_ready) begin
      check("op_timeout", 32'd0, 32'd1);
      bus_q.delete();
      done_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct { logic [31:0] alu; logic [17:0] addr; } map_vec_t;
  map_vec_t map_tbl[6] = '{
    '{32'd1028,     18'h00002},
    '{32'd0,        18'h3FE00},
    '{32'd1024,     18'h00000},
    '{32'd1027,     18'h00000},
    '{32'd1044,     18'h0000A},
    '{32'hFFFFFFFF, 18'h3FDFE}
  };

  initial begin
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    alu_res = 32'd1028; st_val = 32'h0; preload = 1'b1;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
    check("rst_dq_z", {31'b0, SRAM_DQ === 16'hzzzz}, 32'd1);
    check("rst_mem_res", mem_res, 32'h0);
    check("rst_addr", {14'b0, SRAM_ADDR}, 32'h2);
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory instructions: address mapping visible in IDLE, no stall.
    foreach (map_tbl[i]) begin
      alu_res = map_tbl[i].alu;
      #1 check("map_addr", {14'b0, SRAM_ADDR}, {14'b0, map_tbl[i].addr});
      @(posedge clk); #1;
    end

    // Store, load back, store, wrap-around load: all back-to-back.
    do_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'h00002, 32'h00000000);
    do_op(1'b1, 1'b0, 32'd1028, 32'h0,        18'h00002, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 32'd1032, 32'h12345678, 18'h00004, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'd0,    32'h0,        18'h3FE00, 32'hF00DCAFE);
    idle(2);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0,        18'h00004, 32'h12345678);
    idle(2);

    // Reset during the HI phase of a load.
    push_bus(18'h2, 1'b1, 16'h0, 0);
    push_bus(18'h2, 1'b1, 16'h0, 0);
    push_bus(18'h2, 1'b1, 16'h0, 0);
    push_bus(18'h3, 1'b1, 16'h0, 0);
    mem_r_en = 1'b1; alu_res = 32'd1028;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1; mem_r_en = 1'b0;
    #1;
    check("abort_we_n", {31'b0, SRAM_WE_N}, 32'd1);
    check("abort_dq_z", {31'b0, SRAM_DQ === 16'hzzzz}, 32'd1);
    check("abort_mem_res", mem_res, 32'h0);
    check("abort_addr_lo", {14'b0, SRAM_ADDR}, 32'h2);
    check("abort_bus_consumed", bus_q.size(), 32'd0);
    bus_q.delete();
    done_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1 check("post_rst_ready", {31'b0, ready}, 32'd1);
    idle(3);

    check("bus_q_drained", bus_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ARM pipeline, directly downstream of the execute stage. It takes the ALU result as a data address and the store value from the execute/memory pipeline register, then runs a multi-cycle read or write against the off-chip 16-bit SRAM. It freezes the whole pipeline through `ready` until the 32-bit word transfer completes. Non-memory instructions pass with zero added latency.

## Interface
Parameters:
- `PHASE_CYCLES`, default 2: cycles each 16-bit half-access holds address, data and control (≥1).
- `MEM_BASE`, default 32'd1024: data-address offset subtracted before SRAM mapping.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_r_en` in 1: load request for the instruction currently in the stage.
- `mem_w_en` in 1: store request. Never asserted together with `mem_r_en`.
- `alu_res` in 32: byte address from the execute stage.
- `st_val` in 32: store data (value of Rm).
- `ready` out 1: 1 means the stage is complete and the pipeline may advance. 0 freezes all pipeline registers and the PC.
- `mem_res` out 32: last completed load word.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_DQ` inout 16: SRAM data bus. Driven only during write phases, otherwise high-Z.
- `SRAM_WE_N` out 1: SRAM write enable, active low.

## Operation
- Address mapping: `a = alu_res - MEM_BASE` (mod 2^32). Word index is `a[18:2]`, and `a[1:0]` are ignored. `SRAM_ADDR = {a[18:2], h}`, where h=0 selects the low half and h=1 the high half.
- FSM states:
  - IDLE: no access in progress.
  - LO: low half, held PHASE_CYCLES cycles.
  - HI: high half, held PHASE_CYCLES cycles.
  - DONE: access complete.
- Phase counter `cnt` counts 0..PHASE_CYCLES-1 within LO and HI.
- Transitions:
  - IDLE → LO when `mem_r_en|mem_w_en`. Otherwise stay in IDLE.
  - LO → HI when `cnt==PHASE_CYCLES-1`.
  - HI → DONE when `cnt==PHASE_CYCLES-1`.
  - DONE → IDLE unconditionally. A request still asserted in DONE belongs to the completing instruction and must not restart.
- `ready` (combinational):
  - 0 in IDLE with a request, and in LO and HI.
  - 1 in DONE, and in IDLE without a request.
- Write (LO/HI while `mem_w_en`):
  - `SRAM_WE_N`=0 for every cycle of the phase.
  - `SRAM_DQ` = `st_val[15:0]` in LO and `st_val[31:16]` in HI.
- Read (LO/HI while `mem_r_en`):
  - `SRAM_WE_N`=1 and `SRAM_DQ` is Z.
  - On the last cycle of LO, `mem_res[15:0]` is registered from `SRAM_DQ`. On the last cycle of HI, `mem_res[31:16]` is registered from `SRAM_DQ`.
  - `mem_res` holds until the next load completes. Stores never modify it.
- Outside LO/HI: `SRAM_WE_N`=1, `SRAM_DQ` Z, `SRAM_ADDR` = mapped address with h=0.
- Inputs are stable during an access because the upstream pipeline is frozen. The block does not re-latch them.

## Timing
- Reset values: state IDLE, `cnt` 0, `mem_res` 0, `SRAM_WE_N` 1, `SRAM_DQ` Z. After reset, `ready` follows the IDLE rule.
- Access latency: request seen in IDLE at cycle 0. Then LO runs cycles 1..P and HI runs cycles P+1..2P. DONE occurs at cycle 2P+1 with `ready`=1.
- That gives 2P+1 stall cycles: 5 stall cycles at the default P=2.
- The pipeline advances on the edge ending DONE. The next instruction is evaluated in IDLE, so back-to-back memory ops cost 2P+1 stalls each.
- Non-memory instruction: `ready`=1 in the same cycle, no stall.
- Reset mid-access (LO/HI) aborts immediately:
  - `SRAM_WE_N` rises and `SRAM_DQ` floats asynchronously.
  - A partially read word is not committed; `mem_res` resets to 0.
- Address wrap: `alu_res < MEM_BASE` wraps modulo 2^32. Only bits [18:2] are used, with no range check.

## Structure
- Shared package/defines file holds:
  - the state encoding localparams (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3);
  - `MEM_BASE`;
  - the SRAM bus widths (data 16, address 18).
- One natural sub-module: `sram_controller`, which holds the FSM, counter, SRAM pins and `mem_res`.
- `mem_stage` does the address mapping and wires the pipeline signals.

## Test plan
- No request (`mem_r_en`=`mem_w_en`=0), arbitrary `alu_res`: `ready`=1 every cycle, `SRAM_WE_N`=1, `SRAM_DQ` Z.
- Store with `alu_res`=1028, `st_val`=0xDEADBEEF, P=2:
  - `ready` low for 5 cycles.
  - `SRAM_ADDR`=2 with DQ=0xBEEF for 2 cycles, then `SRAM_ADDR`=3 with DQ=0xDEAD for 2 cycles, with `SRAM_WE_N`=0 throughout.
  - `ready`=1 in cycle 6.
- Load back from `alu_res`=1028 with the SRAM model holding those halves: `mem_res`=0xDEADBEEF in the DONE cycle, `ready`=1, and no second access starts.
- Back-to-back load then store: two separate 5-cycle stalls, with exactly one IDLE-evaluation cycle between DONE and the next LO.
- Reset asserted in the HI phase of a load:
  - `SRAM_WE_N`=1, DQ Z and `mem_res`=0 immediately.
  - After release with no request, `ready`=1.
- `alu_res`=0 (wrap): mapped address 0xFFFFFC00, so `SRAM_ADDR` = {0x1FF00, h} = 0x3FE00 / 0x3FE01.
